// File: rtl/fsm_ctrl_pkg.sv
// fsm_ctrl_pkg
// Shared constants for the FIFO-monitor control FSM:
//   - five one-hot state encodings (5 bits each)
//   - width of the ACTIVE->IDLE debounce counter
package fsm_ctrl_pkg;

  localparam int STATE_W = 5;

  localparam logic [STATE_W-1:0] ST_RESET  = 5'b00001;
  localparam logic [STATE_W-1:0] ST_INIT   = 5'b00010;
  localparam logic [STATE_W-1:0] ST_IDLE   = 5'b00100;
  localparam logic [STATE_W-1:0] ST_ACTIVE = 5'b01000;
  localparam logic [STATE_W-1:0] ST_ERROR  = 5'b10000;

  // Wide enough for IDLE_CYC up to 15.
  localparam int IDLE_CNT_W = 4;

endpackage

// File: rtl/idle_debounce.sv
// idle_debounce
// Counts consecutive all-empty cycles while the FSM is ACTIVE and flags the
// cycle on which the FSM may drop back to IDLE.
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous active-high reset
//   en         FSM is in ACTIVE; counter is held at zero otherwise
//   clr        FSM is leaving ACTIVE this cycle for another reason
//   all_empty  every monitored FIFO reports empty this cycle
//   done       combinational: this all-empty cycle is number IDLE_CYC
module idle_debounce
  import fsm_ctrl_pkg::*;
#(
  parameter int IDLE_CYC = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic clr,
  input  logic all_empty,
  output logic done
);

  localparam logic [IDLE_CNT_W-1:0] LAST_CNT = IDLE_CNT_W'(IDLE_CYC - 1);

  logic [IDLE_CNT_W-1:0] cnt_q;
  logic [IDLE_CNT_W-1:0] cnt_d;

  // The count holds the number of all-empty cycles already seen, so the
  // IDLE_CYC-th one is the cycle where it equals IDLE_CYC-1 (IDLE_CYC=1
  // therefore fires on the very first all-empty cycle).
  assign done = en & all_empty & (cnt_q == LAST_CNT);

  always_comb begin
    // NOTE: every variable written here gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    cnt_d = cnt_q;
    if (!en || clr || !all_empty || done) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/fsm_ctrl.sv
// fsm_ctrl
// Control FSM for a bank of monitored FIFOs. Latches an almost-full /
// almost-empty threshold pair during INIT, validates it, then tracks FIFO
// activity (IDLE/ACTIVE) and collects sticky per-FIFO errors in ERROR.
// All outputs are registered (Moore).
// Ports:
//   clk, reset           clock; asynchronous active-high reset
//   init                 request entry to / hold in INIT
//   fifo_error           per-FIFO error flags
//   fifo_empty           per-FIFO empty flags (1 = empty)
//   af_thr_in/ae_thr_in  thresholds sampled while in INIT
//   af_thr/ae_thr        latched thresholds
//   error_out            sticky error vector (nonzero only in ERROR)
//   cfg_error            latched threshold pair invalid (only in ERROR)
//   init_out/idle_out/active_out  state indicators
module fsm_ctrl
  import fsm_ctrl_pkg::*;
#(
  parameter int NUM_FIFOS = 5,
  parameter int TH_W      = 3,
  parameter int IDLE_CYC  = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 init,
  input  logic [NUM_FIFOS-1:0] fifo_error,
  input  logic [NUM_FIFOS-1:0] fifo_empty,
  input  logic [TH_W-1:0]      af_thr_in,
  input  logic [TH_W-1:0]      ae_thr_in,
  output logic [TH_W-1:0]      af_thr,
  output logic [TH_W-1:0]      ae_thr,
  output logic [NUM_FIFOS-1:0] error_out,
  output logic                 cfg_error,
  output logic                 init_out,
  output logic                 idle_out,
  output logic                 active_out
);

  logic [STATE_W-1:0]   state_q,      state_d;
  logic [TH_W-1:0]      af_thr_q,     af_thr_d;
  logic [TH_W-1:0]      ae_thr_q,     ae_thr_d;
  logic [NUM_FIFOS-1:0] error_out_q,  error_out_d;
  logic                 cfg_error_q,  cfg_error_d;
  logic                 init_out_q,   init_out_d;
  logic                 idle_out_q,   idle_out_d;
  logic                 active_out_q, active_out_d;

  logic any_error;
  logic all_empty;
  logic cfg_bad;
  logic in_active;
  logic idle_done;

  assign any_error = |fifo_error;
  assign all_empty = &fifo_empty;
  assign in_active = (state_q == ST_ACTIVE);

  // A usable pair needs a non-zero almost-full level strictly above the
  // almost-empty level.
  assign cfg_bad = (af_thr_in <= ae_thr_in) || (af_thr_in == '0);

  // Error and init override the idle rule, so the count is dropped on any
  // cycle that leaves ACTIVE through them.
  idle_debounce #(
    .IDLE_CYC (IDLE_CYC)
  ) u_idle_debounce (
    .clk       (clk),
    .reset     (reset),
    .en        (in_active),
    .clr       (any_error | init),
    .all_empty (all_empty),
    .done      (idle_done)
  );

  always_comb begin
    state_d     = state_q;
    af_thr_d    = af_thr_q;
    ae_thr_d    = ae_thr_q;
    // Error outputs are zero unless the next state is ERROR.
    error_out_d = '0;
    cfg_error_d = 1'b0;

    case (state_q)
      ST_RESET: begin
        state_d = ST_INIT;
      end

      ST_INIT: begin
        af_thr_d = af_thr_in;
        ae_thr_d = ae_thr_in;
        if (!init) begin
          if (cfg_bad) begin
            state_d     = ST_ERROR;
            cfg_error_d = 1'b1;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end

      ST_IDLE, ST_ACTIVE: begin
        if (any_error) begin
          state_d     = ST_ERROR;
          error_out_d = fifo_error;
        end else if (init) begin
          state_d = ST_INIT;
        end else if (!all_empty) begin
          state_d = ST_ACTIVE;
        end else if (in_active && idle_done) begin
          state_d = ST_IDLE;
        end
      end

      ST_ERROR: begin
        // init beats a simultaneous fifo_error: leave and clear everything.
        if (init) begin
          state_d = ST_INIT;
        end else begin
          error_out_d = error_out_q | fifo_error;
          cfg_error_d = cfg_error_q;
        end
      end

      default: begin
        state_d = ST_RESET;
      end
    endcase

    // Indicators are derived from the next state so they change on the same
    // edge as the state register.
    init_out_d   = (state_d == ST_INIT);
    idle_out_d   = (state_d == ST_IDLE);
    active_out_d = (state_d == ST_ACTIVE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_RESET;
      af_thr_q     <= '0;
      ae_thr_q     <= '0;
      error_out_q  <= '0;
      cfg_error_q  <= 1'b0;
      init_out_q   <= 1'b0;
      idle_out_q   <= 1'b0;
      active_out_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      af_thr_q     <= af_thr_d;
      ae_thr_q     <= ae_thr_d;
      error_out_q  <= error_out_d;
      cfg_error_q  <= cfg_error_d;
      init_out_q   <= init_out_d;
      idle_out_q   <= idle_out_d;
      active_out_q <= active_out_d;
    end
  end

  assign af_thr     = af_thr_q;
  assign ae_thr     = ae_thr_q;
  assign error_out  = error_out_q;
  assign cfg_error  = cfg_error_q;
  assign init_out   = init_out_q;
  assign idle_out   = idle_out_q;
  assign active_out = active_out_q;

endmodule

// File: doc/fsm_ctrl.md
FSM_CTRL -- requirements
Module: fsm_ctrl

Interface
REQ-001 The block SHALL have parameter NUM_FIFOS, default 5, the number of monitored FIFOs.
REQ-002 The block SHALL have parameter TH_W, default 3, the threshold field width.
REQ-003 The block SHALL have parameter IDLE_CYC, default 4 (legal range 1..15), the number of consecutive all-empty cycles required to go from ACTIVE to IDLE.
REQ-004 The block SHALL run on one clock; reset is asynchronous and active-high.
REQ-005 clk  in  1  sole clock, rising edge.
REQ-006 reset  in  1  asynchronous, active-high reset.
REQ-007 init  in  1  request entry to, or hold in, INIT.
REQ-008 fifo_error  in  NUM_FIFOS  per-FIFO error flags.
REQ-009 fifo_empty  in  NUM_FIFOS  per-FIFO empty flags (1 = empty).
REQ-010 af_thr_in  in  TH_W  almost-full threshold to be latched.
REQ-011 ae_thr_in  in  TH_W  almost-empty threshold to be latched.
REQ-012 af_thr  out  TH_W  latched almost-full threshold.
REQ-013 ae_thr  out  TH_W  latched almost-empty threshold.
REQ-014 error_out  out  NUM_FIFOS  sticky error vector.
REQ-015 cfg_error  out  1  the latched threshold pair is invalid.
REQ-016 init_out, idle_out, active_out  out  1 each  state indicators.

Function
REQ-017 The FSM SHALL use five one-hot states: RESET, INIT, IDLE, ACTIVE, ERROR.
REQ-018 All outputs SHALL be registered (Moore); each output SHALL reflect an input change exactly one clk after the edge that samples it.
REQ-019 RESET SHALL go to INIT on the first clk edge after reset deasserts.
REQ-020 In INIT, af_thr/ae_thr SHALL load af_thr_in/ae_thr_in every cycle, and fifo_error and fifo_empty SHALL be ignored.
REQ-021 INIT SHALL stay in INIT while init=1.
REQ-022 When INIT sees init=0, it SHALL go to ERROR with cfg_error=1 if af_thr_in <= ae_thr_in or af_thr_in == 0; otherwise it SHALL go to IDLE.
REQ-023 IDLE and ACTIVE SHALL use this priority: (1) |fifo_error -> ERROR, with error_out loaded from fifo_error; (2) init -> INIT; (3) ~&fifo_empty -> ACTIVE; (4) otherwise the idle rule.
REQ-024 Idle rule: in ACTIVE, a counter of width 4 SHALL increment on each all-empty cycle and clear on any non-empty cycle.
REQ-025 The FSM SHALL go ACTIVE -> IDLE on the all-empty cycle where the counter equals IDLE_CYC-1; IDLE_CYC=1 SHALL give an immediate transition.
REQ-026 The idle counter SHALL clear on entry to ACTIVE and in every other state.
REQ-027 IDLE SHALL stay in IDLE while all FIFOs are empty and no error or init is present.
REQ-028 In ERROR, error_out SHALL accumulate as error_out | fifo_error each cycle.
REQ-029 ERROR SHALL exit only on init=1, going to INIT and clearing error_out and cfg_error on that edge; init wins over a simultaneous fifo_error.
REQ-030 A fifo_error together with init in IDLE/ACTIVE SHALL go to ERROR (error has priority).
REQ-031 Exactly one of init_out, idle_out, active_out SHALL be 1 in INIT, IDLE and ACTIVE respectively; all three SHALL be 0 in RESET and ERROR.
REQ-032 error_out SHALL be nonzero only in ERROR; cfg_error SHALL be 1 only in ERROR.
REQ-033 af_thr/ae_thr SHALL hold their values outside INIT.
REQ-034 An illegal state encoding SHALL return the FSM to RESET on the next edge.

Reset
REQ-035 reset=1 SHALL asynchronously force state=RESET.
REQ-036 reset=1 SHALL asynchronously clear af_thr, ae_thr, error_out, cfg_error, all state indicators and the idle counter to 0.
REQ-037 reset asserted mid-operation (any state) SHALL take effect without waiting for a clk edge.
REQ-038 reset deasserted SHALL give RESET for one cycle, then INIT.

Structure
REQ-039 Package fsm_ctrl_pkg SHALL hold the state encodings (5-bit one-hot localparams) and the idle-counter width constant.
REQ-040 The idle counter SHALL be a sub-module idle_debounce (inputs clk, reset, en, clr, all_empty; output done).
REQ-041 The FSM next-state logic SHALL be a single combinational block with default assignments; no latches.

Verification
REQ-042 Reset, then init=1 for 3 cycles with af=6, ae=2, then init=0 -> IDLE; idle_out=1, af_thr=6, ae_thr=2.
REQ-043 In IDLE, set fifo_empty=5'b11101 -> active_out=1 next cycle; then set all empty with IDLE_CYC=4 -> idle_out=1 exactly 4 cycles later; a single non-empty pulse at cycle 3 restarts the count.
REQ-044 In ACTIVE, pulse fifo_error=5'b00100, then 5'b00001 -> error_out=5'b00100, then 5'b00101; the value persists with errors low; init=1 -> INIT and error_out=0.
REQ-045 INIT with af=2, ae=3, then init=0 -> ERROR, cfg_error=1, error_out=0.
REQ-046 fifo_error=5'b10000 and init=1 together in IDLE -> ERROR, error_out=5'b10000.
REQ-047 reset asserted mid-ACTIVE between clk edges -> all outputs 0 immediately; after deassert, RESET then INIT.
